uart_stim_tx: RTL and testbench

//  Parametrised UART frame generator that drives a CPU `rx` pin for system-level sim and on-board loopback.

---
 rtl/uart_stim_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_stim_tx.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stim_tx.sv
// UART frame generator for driving a CPU rx pin: byte FIFO feeding a serialiser FSM
// with configurable baud divisor, parity, stop bits, inter-frame gap and error injection.
module uart_stim_tx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 20,
  parameter int FIFO_AW      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 inj_par,
  input  logic                 inj_frm,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 overflow,
  output logic                 frame_done,
  output logic [2:0]           fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int IW      = 3;
  localparam logic [CW-1:0]    BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    GAP_LOAD  = (GAP_CLKS > 0) ? CW'(GAP_CLKS - 1) : '0;
  localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic             ODD_PAR   = (PARITY == 2);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wptr, rptr;
  logic [FIFO_AW:0]     level_nxt;
  logic                 pop, push;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bit, frm_bit;

  // A pop frees the head slot in the same cycle, so a write while full is still taken.
  assign pop       = (state == S_IDLE) && !empty;
  assign push      = wr_en && (!full || pop);
  assign fsm_state = state;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_LVL);
      empty <= (level_nxt == '0);
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      frm_bit    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            sh      <= mem[rptr];
            par_bit <= (^mem[rptr]) ^ ODD_PAR ^ inj_par;
            frm_bit <= inj_frm;
            tx_out  <= 1'b0;
            busy    <= 1'b1;
            cnt     <= BIT_LOAD;
            state   <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            tx_out <= sh[0];
            sh     <= sh >> 1;
            idx    <= '0;
            cnt    <= BIT_LOAD;
            state  <= S_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= BIT_LOAD;
            if (idx == IW'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                tx_out <= par_bit;
                state  <= S_PARITY;
              end else begin
                tx_out <= ~frm_bit;
                idx    <= '0;
                state  <= S_STOP;
              end
            end else begin
              tx_out <= sh[0];
              sh     <= sh >> 1;
              idx    <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == '0) begin
            tx_out <= ~frm_bit;
            idx    <= '0;
            cnt    <= BIT_LOAD;
            state  <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            tx_out <= 1'b1;
            if (idx == IW'(STOP_BITS - 1)) begin
              frame_done <= 1'b1;
              if (GAP_CLKS != 0) begin
                cnt   <= GAP_LOAD;
                state <= S_GAP;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
              cnt <= BIT_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: three configurations (default, even parity, odd/7-bit/2-stop/no-gap)
// with a line receiver decoding tx_out and an expected-byte queue.
module tb_uart_stim_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic       wr_en0 = 0, inj_par0 = 0, inj_frm0 = 0;
  logic [7:0] wr_data0 = 0;
  logic       tx0, busy0, full0, empty0, overflow0, done0;
  logic [3:0] level0;
  logic [2:0] st0;
  // even parity
  logic       wr_en1 = 0, inj_par1 = 0, inj_frm1 = 0;
  logic [7:0] wr_data1 = 0;
  logic       tx1, busy1, full1, empty1, overflow1, done1;
  logic [3:0] level1;
  logic [2:0] st1;
  // odd parity, 7 data bits, 2 stop bits, 3 clks per bit, no gap
  logic       wr_en2 = 0, inj_par2 = 0, inj_frm2 = 0;
  logic [6:0] wr_data2 = 0;
  logic       tx2, busy2, full2, empty2, overflow2, done2;
  logic [3:0] level2;
  logic [2:0] st2;

  uart_stim_tx u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0), .inj_par(inj_par0),
    .inj_frm(inj_frm0), .tx_out(tx0), .busy(busy0), .full(full0), .empty(empty0),
    .level(level0), .overflow(overflow0), .frame_done(done0), .fsm_state(st0));

  uart_stim_tx #(.PARITY(1)) u_even (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .inj_par(inj_par1),
    .inj_frm(inj_frm1), .tx_out(tx1), .busy(busy1), .full(full1), .empty(empty1),
    .level(level1), .overflow(overflow1), .frame_done(done1), .fsm_state(st1));

  uart_stim_tx #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .GAP_CLKS(0)) u_odd (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2), .inj_par(inj_par2),
    .inj_frm(inj_frm2), .tx_out(tx2), .busy(busy2), .full(full2), .empty(empty2),
    .level(level2), .overflow(overflow2), .frame_done(done2), .fsm_state(st2));

  function automatic logic tx_of(input int sel);
    case (sel)
      1:       return tx1;
      2:       return tx2;
      default: return tx0;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      1:       return done1;
      2:       return done2;
      default: return done0;
    endcase
  endfunction

  task automatic drive(input int sel, input logic en, input logic [7:0] d);
    case (sel)
      1:       begin wr_en1 = en; wr_data1 = d; end
      2:       begin wr_en2 = en; wr_data2 = d[6:0]; end
      default: begin wr_en0 = en; wr_data0 = d; end
    endcase
  endtask

  // Expected serial line, bit 0 = start bit, one entry per bit period.
  function automatic logic [15:0] build_line(input logic [7:0] d, input int nbits, input int pmode,
                                             input logic ip, input logic ifr, input int nstop);
    logic [15:0] l;
    logic x;
    int p;
    l = '0; x = 1'b0; p = 1;
    for (int i = 0; i < nbits; i++) begin l[p] = d[i]; x ^= d[i]; p++; end
    if (pmode != 0) begin l[p] = x ^ (pmode == 2) ^ ip; p++; end
    l[p] = ~ifr; p++;
    if (nstop == 2) l[p] = 1'b1;
    return l;
  endfunction

  // Call at a negedge while the line is idle; returns at the negedge after the frame's last edge.
  task automatic get_frame(input int sel, input int cpb, input int nbits, input int has_par,
                           input int nstop, output logic [15:0] line, output bit glitch,
                           output int start_cyc, output bit done_ok);
    int n, total;
    logic v;
    line = '0; glitch = 0; done_ok = 1; start_cyc = -1; n = 0;
    while (tx_of(sel) !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin line = 'x; glitch = 1; done_ok = 0; return; end
    start_cyc = cyc;
    total = 1 + nbits + has_par + nstop;
    for (int b = 0; b < total; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        v = tx_of(sel);
        if (c == 0) line[b] = v;
        else if (v !== line[b]) glitch = 1;
        if (done_of(sel) !== 1'b0) done_ok = 0;
      end
    end
    @(negedge clk);
    if (done_of(sel) !== 1'b1) done_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx0, busy0, full0, empty0, level0, overflow0, done0} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got tx=%b busy=%b full=%b empty=%b level=%0d ovf=%b done=%b, want 1 0 0 1 0 0 0",
               tx0, busy0, full0, empty0, level0, overflow0, done0);
    end
    n_checks++;
    if ({tx1, tx2, busy1, busy2} !== 4'b1100) begin
      n_errors++;
      $display("FAIL reset_other: got tx1=%b tx2=%b busy1=%b busy2=%b, want 1 1 0 0", tx1, tx2, busy1, busy2);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [15:0] line, want;
    bit gl, dok;
    int st, push_edge;
    logic [7:0] e;
    push_edge = cyc + 1;
    drive(0, 1, 8'h05); exp_q.push_back(8'h05);
    @(negedge clk);
    drive(0, 0, 8'h00);
    get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
    e = exp_q.pop_front();
    want = build_line(e, 8, 0, 0, 0, 1);
    n_checks++;
    if (st !== push_edge + 1) begin
      n_errors++; $display("FAIL single_latency: start edge %0d, want %0d", st, push_edge + 1);
    end
    n_checks++;
    if (line !== want || gl) begin
      n_errors++; $display("FAIL single_bits: line=%b glitch=%0d, want %b", line, gl, want);
    end
    n_checks++;
    if (!dok) begin
      n_errors++; $display("FAIL single_done: frame_done not a pulse 20 cycles after start (got bad), want pulse");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5] = '{8'h05, 8'h02, 8'h01, 8'h04, 8'h03};
    int max_lvl = 0;
    bit saw_full = 0;
    int prev_st = -1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          drive(0, 1, bytes[i]); exp_q.push_back(bytes[i]);
          @(negedge clk);
        end
        drive(0, 0, 8'h00);
      end
      begin
        for (int i = 0; i < 230; i++) begin
          if (int'(level0) > max_lvl) max_lvl = int'(level0);
          if (full0) saw_full = 1;
          @(negedge clk);
        end
      end
      begin
        logic [15:0] line;
        bit gl, dok;
        int st;
        logic [7:0] e;
        for (int f = 0; f < 5; f++) begin
          get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL b2b_data: unexpected frame %b, want none", line);
          end else begin
            e = exp_q.pop_front();
            if (line !== build_line(e, 8, 0, 0, 0, 1) || gl || !dok) begin
              n_errors++;
              $display("FAIL b2b_data: frame %0d line=%b glitch=%0d done_ok=%0d, want %b", f, line, gl, dok,
                       build_line(e, 8, 0, 0, 0, 1));
            end
          end
          if (prev_st >= 0) begin
            n_checks++;
            if (st - prev_st !== 41) begin
              n_errors++; $display("FAIL b2b_period: frame %0d start spacing %0d, want 41", f, st - prev_st);
            end
          end
          prev_st = st;
        end
      end
    join
    // The first write is popped one edge after it lands, so occupancy peaks at 4 of the 5.
    n_checks++;
    if (max_lvl !== 4 || saw_full || level0 !== 4'd0 || empty0 !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_level: max=%0d full_seen=%0d end_level=%0d empty=%b, want 4 0 0 1",
               max_lvl, saw_full, level0, empty0);
    end
  endtask

  task automatic test_overflow();
    fork
      begin
        drive(0, 1, 8'hC3); exp_q.push_back(8'hC3);
        @(negedge clk);
        drive(0, 0, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          drive(0, 1, 8'(8'h10 + i));
          if (i < 8) exp_q.push_back(8'(8'h10 + i));
          @(negedge clk);
          if (i == 7) begin
            n_checks++;
            if (full0 !== 1'b1 || overflow0 !== 1'b0 || level0 !== 4'd8) begin
              n_errors++;
              $display("FAIL ovf_full: full=%b ovf=%b level=%0d, want 1 0 8", full0, overflow0, level0);
            end
          end
        end
        drive(0, 0, 8'h00);
        n_checks++;
        if (overflow0 !== 1'b1 || level0 !== 4'd8 || full0 !== 1'b1) begin
          n_errors++;
          $display("FAIL ovf_drop: ovf=%b level=%0d full=%b, want 1 8 1", overflow0, level0, full0);
        end
      end
      begin
        logic [15:0] line;
        bit gl, dok;
        int st;
        logic [7:0] e;
        for (int f = 0; f < 9; f++) begin
          get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++; $display("FAIL ovf_data: unexpected frame %b, want none", line);
          end else begin
            e = exp_q.pop_front();
            if (line !== build_line(e, 8, 0, 0, 0, 1) || gl || !dok) begin
              n_errors++;
              $display("FAIL ovf_data: frame %0d line=%b, want %b", f, line, build_line(e, 8, 0, 0, 0, 1));
            end
          end
        end
      end
    join
    repeat (25) @(negedge clk);
    n_checks++;
    if (overflow0 !== 1'b1 || empty0 !== 1'b1 || busy0 !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL ovf_after: ovf=%b empty=%b busy=%b pending=%0d, want 1 1 0 0",
               overflow0, empty0, busy0, exp_q.size());
    end
  endtask

  task automatic test_parity();
    logic [15:0] line, want;
    bit gl, dok;
    int st;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      inj_par1 = (k == 1);
      drive(1, 1, 8'h07); exp_q.push_back(8'h07);
      @(negedge clk);
      drive(1, 0, 8'h00);
      get_frame(1, 2, 8, 1, 1, line, gl, st, dok);
      e = exp_q.pop_front();
      want = build_line(e, 8, 1, inj_par1, 0, 1);
      n_checks++;
      if (line !== want || gl || !dok || line[9] !== (k == 0)) begin
        n_errors++;
        $display("FAIL even_parity: inj=%0d line=%b, want %b", k, line, want);
      end
      inj_par1 = 1'b0;
      repeat (22) @(negedge clk);
    end
    // Odd parity, 7-bit payload, two stop bits, no gap: frames every 34 cycles.
    fork
      begin
        drive(2, 1, 8'h07); exp_q.push_back(8'h07);
        @(negedge clk);
        drive(2, 1, 8'h55); exp_q.push_back(8'h55);
        @(negedge clk);
        drive(2, 0, 8'h00);
      end
      begin
        int prev = -1;
        for (int f = 0; f < 2; f++) begin
          get_frame(2, 3, 7, 1, 2, line, gl, st, dok);
          e = exp_q.pop_front();
          want = build_line(e, 7, 2, 0, 0, 2);
          n_checks++;
          if (line !== want || gl || !dok) begin
            n_errors++; $display("FAIL odd_parity: frame %0d line=%b, want %b", f, line, want);
          end
          if (prev >= 0) begin
            n_checks++;
            if (st - prev !== 34) begin
              n_errors++; $display("FAIL odd_period: spacing %0d, want 34", st - prev);
            end
          end
          prev = st;
        end
      end
    join
    inj_par2 = 1'b1;
    drive(2, 1, 8'h07); exp_q.push_back(8'h07);
    @(negedge clk);
    drive(2, 0, 8'h00);
    get_frame(2, 3, 7, 1, 2, line, gl, st, dok);
    inj_par2 = 1'b0;
    e = exp_q.pop_front();
    want = build_line(e, 7, 2, 1, 0, 2);
    n_checks++;
    if (line !== want || gl || !dok || line[8] !== 1'b1) begin
      n_errors++; $display("FAIL odd_inj_par: line=%b, want %b", line, want);
    end
  endtask

  task automatic test_framing();
    logic [15:0] line, want;
    bit gl, dok, low_seen;
    int st;
    logic [7:0] e;
    inj_frm0 = 1'b1;
    drive(0, 1, 8'hFF); exp_q.push_back(8'hFF);
    @(negedge clk);
    drive(0, 0, 8'h00);
    get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
    inj_frm0 = 1'b0;
    e = exp_q.pop_front();
    want = build_line(e, 8, 0, 0, 1, 1);
    n_checks++;
    if (line !== want || gl || !dok) begin
      n_errors++; $display("FAIL frm_stop: line=%b glitch=%0d, want %b", line, gl, want);
    end
    low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx0 !== 1'b1) low_seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (low_seen) begin
      n_errors++; $display("FAIL frm_gap: line went low during gap, want high");
    end
    drive(0, 1, 8'h81); exp_q.push_back(8'h81);
    @(negedge clk);
    drive(0, 0, 8'h00);
    get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
    e = exp_q.pop_front();
    want = build_line(e, 8, 0, 0, 0, 1);
    n_checks++;
    if (line !== want || gl || !dok) begin
      n_errors++; $display("FAIL frm_next: line=%b, want %b", line, want);
    end
    repeat (22) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] line, want;
    bit gl, dok, bad;
    int st, n;
    logic [7:0] e;
    drive(0, 1, 8'hA5);
    @(negedge clk);
    drive(0, 1, 8'h11);
    @(negedge clk);
    drive(0, 0, 8'h00);
    n = 0;
    while (tx0 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    st = cyc;
    while (cyc < st + 8 && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (tx0 !== 1'b0 || n >= 200) begin
      n_errors++; $display("FAIL mid_bit3: tx=%b (waited %0d), want 0 (bit 3 of A5)", tx0, n);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if ({tx0, busy0, level0, empty0, overflow0, done0} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset: tx=%b busy=%b level=%0d empty=%b ovf=%b done=%b, want 1 0 0 1 0 0",
               tx0, busy0, level0, empty0, overflow0, done0);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0 !== 1'b0 || tx0 !== 1'b1) bad = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL mid_quiet: frame_done or line activity after reset, want none");
    end
    drive(0, 1, 8'h3C); exp_q.push_back(8'h3C);
    @(negedge clk);
    drive(0, 0, 8'h00);
    get_frame(0, 2, 8, 0, 1, line, gl, st, dok);
    e = exp_q.pop_front();
    want = build_line(e, 8, 0, 0, 0, 1);
    n_checks++;
    if (line !== want || gl || !dok) begin
      n_errors++; $display("FAIL mid_resume: line=%b, want %b", line, want);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    repeat (25) @(negedge clk);
    test_back_to_back();
    repeat (25) @(negedge clk);
    test_overflow();
    test_parity();
    test_framing();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
